// File: rtl/mux_pkg.sv
// Shared types and sizing helpers for the design pin-mux switch controller.
package mux_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      QUIESCE = 2'd1,
      RESET   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int SEL_BITS_DEF = 5;

   // The timer counts down from (cycles - 1), so it needs clog2 of the larger hold time.
   function automatic int timer_w(input int quiesce_cycles, input int reset_cycles);
      int m;
      m = (quiesce_cycles > reset_cycles) ? quiesce_cycles : reset_cycles;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for pad inputs, cleared by async active-low reset.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/mux_switch_ctrl.sv
// Debounces the design-select pads and sequences a glitch-free hand-over:
// outputs off, design reset, mux select update, reset release, outputs on.
//
//   state   | meaning
//   RUN     | design active, outputs enabled, debouncing select pads
//   QUIESCE | outputs disabled, waiting before asserting design reset
//   RESET   | design reset held low with the new select applied
//   RELEASE | reset released, one cycle before outputs re-enable
module mux_switch_ctrl
   import mux_pkg::*;
#(
   parameter int SEL_BITS       = SEL_BITS_DEF,
   parameter int DEBOUNCE       = 4,
   parameter int QUIESCE_CYCLES = 2,
   parameter int RESET_CYCLES   = 8,
   parameter int CNT_W          = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SEL_BITS-1:0] sel_req,
   output logic [SEL_BITS-1:0] sel,
   output logic                design_rst_n,
   output logic                out_en,
   output logic                busy,
   output logic [CNT_W-1:0]    switch_cnt
);

   localparam int TMR_W  = timer_w(QUIESCE_CYCLES, RESET_CYCLES);
   localparam int DCNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [TMR_W-1:0]  QUIESCE_LOAD = TMR_W'(QUIESCE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  RESET_LOAD   = TMR_W'(RESET_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST    = DCNT_W'(DEBOUNCE - 1);
   localparam logic [DCNT_W-1:0] DCNT_ONE     = DCNT_W'(1);

   state_t              r_state, w_state_nxt;
   logic [TMR_W-1:0]    r_timer, w_timer_nxt;
   logic [SEL_BITS-1:0] r_sel, w_sel_nxt;
   logic [SEL_BITS-1:0] r_cand, w_cand_nxt;
   logic [DCNT_W-1:0]   r_dcnt, w_dcnt_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_drst_n, w_drst_n_nxt;
   logic                r_out_en, w_out_en_nxt;
   logic                w_commit;
   logic [SEL_BITS-1:0] w_sel_sync;

   sync2 #(.WIDTH(SEL_BITS)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (sel_req),
      .o_q   (w_sel_sync)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_sel_nxt    = r_sel;
      w_cand_nxt   = r_cand;
      w_dcnt_nxt   = '0;
      w_cnt_nxt    = r_cnt;
      w_drst_n_nxt = r_drst_n;
      w_out_en_nxt = r_out_en;
      w_commit     = 1'b0;
      unique case (r_state)
         RUN: begin
            // dcnt == 0 means no live candidate, so a stale cand never shortens the count
            if (w_sel_sync == r_sel) begin
               w_dcnt_nxt = '0;
            end else if ((w_sel_sync != r_cand) || (r_dcnt == '0)) begin
               w_cand_nxt = w_sel_sync;
               w_dcnt_nxt = DCNT_ONE;
               w_commit   = (DEBOUNCE == 1);
            end else begin
               w_dcnt_nxt = r_dcnt + 1'b1;
               w_commit   = (r_dcnt == DCNT_LAST);
            end
            if (w_commit) begin
               w_state_nxt  = QUIESCE;
               w_out_en_nxt = 1'b0;
               w_timer_nxt  = QUIESCE_LOAD;
               w_dcnt_nxt   = '0;
            end
         end
         QUIESCE: begin
            if (r_timer == '0) begin
               w_state_nxt  = RESET;
               w_sel_nxt    = r_cand;
               w_drst_n_nxt = 1'b0;
               w_cnt_nxt    = r_cnt + 1'b1;
               w_timer_nxt  = RESET_LOAD;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         RESET: begin
            w_cand_nxt = '0;
            if (r_timer == '0) begin
               w_state_nxt  = RELEASE;
               w_drst_n_nxt = 1'b1;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         RELEASE: begin
            w_cand_nxt   = '0;
            w_state_nxt  = RUN;
            w_out_en_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = RESET;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= RESET;
         r_timer  <= RESET_LOAD;
         r_sel    <= '0;
         r_cand   <= '0;
         r_dcnt   <= '0;
         r_cnt    <= '0;
         r_drst_n <= 1'b0;
         r_out_en <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_sel    <= w_sel_nxt;
         r_cand   <= w_cand_nxt;
         r_dcnt   <= w_dcnt_nxt;
         r_cnt    <= w_cnt_nxt;
         r_drst_n <= w_drst_n_nxt;
         r_out_en <= w_out_en_nxt;
      end
   end

   assign sel          = r_sel;
   assign design_rst_n = r_drst_n;
   assign out_en       = r_out_en;
   assign switch_cnt   = r_cnt;
   assign busy         = (r_state != RUN);

endmodule

// File: tb/tb_mux_switch_ctrl.sv
// Directed bench for mux_switch_ctrl: scoreboard of expected results checked on each out_en rise.
module tb_mux_switch_ctrl;
   import mux_pkg::*;

   localparam int SB = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [SB-1:0] sel_req = '0;
   logic [SB-1:0] sel, w_sel;
   logic          drst, oen, busy, w_drst, w_oen, w_busy;
   logic [7:0]    cnt;
   logic [1:0]    w_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [SB-1:0] sel;
      logic [7:0]    cnt;
      logic [1:0]    wcnt;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mux_switch_ctrl u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sel_req      (sel_req),
      .sel          (sel),
      .design_rst_n (drst),
      .out_en       (oen),
      .busy         (busy),
      .switch_cnt   (cnt)
   );

   mux_switch_ctrl #(.CNT_W(2)) u_wrap (
      .clk          (clk),
      .rst_n        (rst_n),
      .sel_req      (sel_req),
      .sel          (w_sel),
      .design_rst_n (w_drst),
      .out_en       (w_oen),
      .busy         (w_busy),
      .switch_cnt   (w_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_oen(input logic v, input int max, input string name);
      int k;
      k = 0;
      while (oen !== v && k < max) begin
         step();
         k++;
      end
      chk(name, oen, v);
   endtask

   // Monitor: pops the scoreboard on every completed hand-over and checks ordering.
   logic          prev_oen = 1'b0;
   logic [SB-1:0] prev_sel = '0;
   always @(negedge clk) begin
      exp_t e;
      if (oen === 1'b1 && prev_oen === 1'b0) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: out_en rose with sel=%0d, required no completion", sel);
         end else begin
            e = sb_q.pop_front();
            chk("sb_sel", sel, e.sel);
            chk("sb_cnt", cnt, e.cnt);
            chk("sb_wrap_sel", w_sel, e.sel);
            chk("sb_wrap_cnt", w_cnt, e.wcnt);
         end
      end
      if (sel !== prev_sel) chk("sel_order_oen_drst", {oen, drst}, 2'b00);
      prev_oen = oen;
      prev_sel = sel;
   end

   task automatic boot();
      rst_n   = 1'b0;
      sel_req = '0;
      step(2);
      chk("rst_sel", sel, 0);
      chk("rst_drst", drst, 0);
      chk("rst_oen", oen, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_busy", busy, 1);
      sb_q.push_back('{sel: 5'd0, cnt: 8'd0, wcnt: 2'd0});
      rst_n = 1'b1;
      step(7);
      chk("boot_drst_low", drst, 0);
      step(1);
      chk("boot_drst_rise", drst, 1);
      chk("boot_oen_low", oen, 0);
      step(1);
      chk("boot_oen_rise", oen, 1);
      chk("boot_busy", busy, 0);
   endtask

   initial begin
      logic saw;
      int   vals[5];
      vals = '{1, 2, 1, 2, 1};
      #2;
      boot();

      // 3-cycle glitch to 3
      saw = 1'b0;
      for (int i = 0; i < 15; i++) begin
         sel_req = (i < 3) ? 5'd3 : 5'd0;
         step();
         if (busy) saw = 1'b1;
      end
      chk("glitch1_busy", saw, 0);
      chk("glitch1_sel", sel, 0);
      chk("glitch1_cnt", cnt, 0);

      // 0 -> 3 -> 7 -> 0, each held 3 cycles
      saw = 1'b0;
      for (int i = 0; i < 18; i++) begin
         sel_req = (i < 3) ? 5'd3 : (i < 6) ? 5'd7 : 5'd0;
         step();
         if (busy) saw = 1'b1;
      end
      chk("glitch2_busy", saw, 0);
      chk("glitch2_sel", sel, 0);
      chk("glitch2_cnt", cnt, 0);

      // clean switch to 5
      sel_req = 5'd5;
      sb_q.push_back('{sel: 5'd5, cnt: 8'd1, wcnt: 2'd1});
      step(5);
      chk("sw_oen_before", oen, 1);
      step(1);
      chk("sw_oen_fall", oen, 0);
      chk("sw_busy", busy, 1);
      step(1);
      chk("sw_sel_hold", sel, 0);
      chk("sw_drst_hold", drst, 1);
      step(1);
      chk("sw_sel", sel, 5);
      chk("sw_drst_low", drst, 0);
      chk("sw_cnt", cnt, 1);

      // request 9 during RESET: ignored until back in RUN
      sel_req = 5'd9;
      sb_q.push_back('{sel: 5'd9, cnt: 8'd2, wcnt: 2'd2});
      step(7);
      chk("sw_rst_len", drst, 0);
      chk("sw_sel_kept", sel, 5);
      step(1);
      chk("sw_drst_rise", drst, 1);
      chk("sw_oen_low", oen, 0);
      step(1);
      chk("sw_oen_rise", oen, 1);
      chk("sw_sel_final", sel, 5);
      step(3);
      chk("sw2_oen_before", oen, 1);
      step(1);
      chk("sw2_commit", oen, 0);
      wait_oen(1'b1, 20, "sw2_done");
      chk("sw2_sel", sel, 9);
      chk("sw2_cnt", cnt, 2);

      // async reset in the middle of RESET with sel=5
      sel_req = 5'd5;
      step(10);
      chk("mid_sel", sel, 5);
      chk("mid_drst", drst, 0);
      #2;
      rst_n   = 1'b0;
      sel_req = 5'd0;
      #1;
      chk("arst_sel", sel, 0);
      chk("arst_drst", drst, 0);
      chk("arst_oen", oen, 0);
      chk("arst_cnt", cnt, 0);
      chk("arst_wrap_cnt", w_cnt, 0);
      boot();

      // five switches: 2-bit counter wraps to 1
      for (int k = 1; k <= 5; k++) begin
         sel_req = SB'(vals[k-1]);
         sb_q.push_back('{sel: SB'(vals[k-1]), cnt: 8'(k), wcnt: 2'(k)});
         wait_oen(1'b0, 20, "wrap_commit");
         wait_oen(1'b1, 30, "wrap_done");
      end
      step(2);
      chk("wrap_cnt", w_cnt, 1);
      chk("full_cnt", cnt, 5);
      chk("wrap_sel", w_sel, 1);
      chk("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at 200000, required finish");
      $fatal(1);
   end

endmodule
